if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. Owns the program counter and drives a request/ready handshake to instruction memory. Selects the next PC from sequential, branch and jump sources and presents one fetched instruction per accepted cycle as IF_PC / IF_ir / IF_valid to IF/ID. Handles downstream stalls and multi-cycle memory, and discards responses made stale by a redirect.

## Interface
- pc_size, 18, width of PC and instruction-memory address
- data_size, 32, instruction width
- reset_pc, 0, PC value after reset
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- PCStall  input  1  1 = downstream holds IF/ID; output slot and PC frozen
- Branch  input  1  take branch this cycle
- BranchAddr  input  pc_size  branch target
- Jump  input  1  take jump this cycle; priority over Branch
- JumpAddr  input  pc_size  jump target
- im_req  output  1  instruction-memory request
- im_addr  output  pc_size  request address, stable while im_req=1 and im_ready=0
- im_ready  input  1  memory returns im_data this cycle
- im_data  input  data_size  instruction word
- IF_PC  output  pc_size  PC+4 of the delivered instruction
- IF_ir  output  data_size  delivered instruction; 0 (NOP) for a bubble
- IF_valid  output  1  slot holds a real instruction

## Operation
- Registers: PC, state, req_addr, hold buffer (data_size), output slot {IF_PC, IF_ir, IF_valid}.
- Redirect = Jump | Branch. Target = JumpAddr if Jump, else BranchAddr. Redirect overrides PCStall.
- Bubble = {IF_PC=0, IF_ir=0, IF_valid=0}.
- All PC arithmetic is modulo 2^pc_size. PC+4 wraps silently: 0x3FFFC+4 = 0x00000.
- States:
  - FETCH
    - Outputs: im_req=1, im_addr=PC.
    - Redirect: PC<=target; slot<=bubble. If im_ready=1, data is dropped and state stays FETCH. If im_ready=0, req_addr<=PC and go to DISCARD.
    - Else im_ready=1 and PCStall=0: slot<={PC+4, im_data, 1}; PC<=PC+4.
    - Else im_ready=1 and PCStall=1: buffer<=im_data; go to HOLD; PC and slot unchanged.
    - Else im_ready=0: slot<=bubble if PCStall=0, held if PCStall=1.
  - HOLD
    - Outputs: im_req=0.
    - Redirect: buffer discarded; PC<=target; slot<=bubble; go to FETCH.
    - Else PCStall=0: slot<={PC+4, buffer, 1}; PC<=PC+4; go to FETCH.
    - Else: stay in HOLD.
  - DISCARD
    - Outputs: im_req=1, im_addr=req_addr. The abandoned request must complete per protocol.
    - A further redirect updates PC to the newest target.
    - Slot: bubble if PCStall=0, held otherwise.
    - im_ready=1: data dropped; go to FETCH.
- Reset (asynchronous, any state, including mid-request):
  - PC=reset_pc, state=FETCH, req_addr=0, buffer=0, IF_PC=0, IF_ir=0, IF_valid=0.
  - im_req is forced to 0 while rst=1.
  - Memory shares rst, so any outstanding request is abandoned.

## Timing
- im_req and im_addr are combinational from state, PC, req_addr and rst. The slot is registered.
- Zero-wait memory (im_ready tied 1): one instruction per cycle. The instruction at address A appears in the slot on the first rising edge after im_addr=A.
- Redirect at edge N: im_addr=target during cycle N+1 (FETCH). The target instruction is in the slot after edge N+1 with zero-wait memory. If the old request was outstanding, it arrives one edge after the DISCARD response.
- PCStall=1 for k cycles: slot, PC and im_addr are constant for those k edges. At most one response is buffered. No instruction is lost or duplicated.
- Simultaneous Jump and Branch: Jump wins.
- Simultaneous redirect and PCStall: redirect wins.

## Test plan
- Reset release with reset_pc=0 and im_ready=1, memory returning word = address | 0xA5000000 -> slot sequence IF_PC 4,8,12 with IF_ir 0xA5000000, 0xA5000004, 0xA5000008, and IF_valid=1 each cycle.
- PCStall=1 for 3 cycles while FETCH at PC=0x10 with im_ready=1 -> enter HOLD, im_req=0, slot frozen. On release, slot gets {0x14, word@0x10, 1}, followed by im_addr=0x14.
- im_ready=0 for 2 cycles at PC=0x20, Branch=1 BranchAddr=0x100 on the first cycle -> DISCARD with im_addr=0x20 until ready. Word@0x20 is never delivered. Next im_addr=0x100.
- Jump=1 JumpAddr=0x200 and Branch=1 BranchAddr=0x300 on the same edge -> im_addr=0x200 and a bubble in the slot.
- PC=0x3FFFC with a normal fetch -> IF_PC=0x00000 and next im_addr=0x00000.
- rst pulsed asynchronously mid-cycle in DISCARD -> outputs are zero immediately and im_req=0. After release, im_addr=reset_pc and state is FETCH.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Purpose : instruction-fetch stage; owns the PC, requests instruction memory, feeds IF/ID.
// Latency : one edge from im_ready to the slot; one instruction per cycle with zero-wait memory.
// Backpr. : PCStall freezes slot and PC, one early response parked in a hold buffer; redirects override.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   PCStall                  downstream holds IF/ID
//   Branch/BranchAddr        branch redirect and target
//   Jump/JumpAddr            jump redirect and target (wins over Branch)
//   im_req/im_addr           instruction-memory request and address (combinational)
//   im_ready/im_data         instruction-memory response
//   IF_PC/IF_ir/IF_valid     registered output slot: PC+4, instruction word, valid
module if_fetch_unit #(
    parameter int                  pc_size   = 18,
    parameter int                  data_size = 32,
    parameter logic [pc_size-1:0]  reset_pc  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PCStall,
    input  logic                 Branch,
    input  logic [pc_size-1:0]   BranchAddr,
    input  logic                 Jump,
    input  logic [pc_size-1:0]   JumpAddr,
    output logic                 im_req,
    output logic [pc_size-1:0]   im_addr,
    input  logic                 im_ready,
    input  logic [data_size-1:0] im_data,
    output logic [pc_size-1:0]   IF_PC,
    output logic [data_size-1:0] IF_ir,
    output logic                 IF_valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [pc_size-1:0]   pc;
        logic [data_size-1:0] ir;
        logic                 vld;
    } slot_t;

    localparam slot_t BUBBLE = '{pc: '0, ir: '0, vld: 1'b0};

    state_t               state_q,   state_nxt;
    logic [pc_size-1:0]   pc_q,      pc_nxt;
    logic [pc_size-1:0]   req_addr_q, req_addr_nxt;
    logic [data_size-1:0] hold_dat_q, hold_dat_nxt;
    slot_t                slot_q,    slot_nxt;

    logic                 redirect;
    logic [pc_size-1:0]   target;
    logic [pc_size-1:0]   pc_inc;

    assign redirect = Jump | Branch;
    assign target   = Jump ? JumpAddr : BranchAddr;
    // Truncating add: the PC wraps silently at 2^pc_size.
    assign pc_inc   = pc_q + pc_size'(4);

    // Request side is combinational so a redirect is visible on the bus the
    // cycle right after the edge that took it. An abandoned request keeps its
    // original address until memory answers it.
    assign im_req  = ~rst & (state_q != HOLD);
    assign im_addr = (state_q == DISCARD) ? req_addr_q : pc_q;

    assign IF_PC    = slot_q.pc;
    assign IF_ir    = slot_q.ir;
    assign IF_valid = slot_q.vld;

    always_comb begin
        state_nxt    = state_q;
        pc_nxt       = pc_q;
        req_addr_nxt = req_addr_q;
        hold_dat_nxt = hold_dat_q;
        slot_nxt     = slot_q;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_nxt   = target;
                    slot_nxt = BUBBLE;
                    if (!im_ready) begin
                        // Memory still owes us a word for the old PC; remember
                        // its address so the request stays stable until it lands.
                        req_addr_nxt = pc_q;
                        state_nxt    = DISCARD;
                    end
                end else if (im_ready && !PCStall) begin
                    slot_nxt = '{pc: pc_inc, ir: im_data, vld: 1'b1};
                    pc_nxt   = pc_inc;
                end else if (im_ready) begin
                    // Word arrived while IF/ID is frozen: park it, stop requesting.
                    hold_dat_nxt = im_data;
                    state_nxt    = HOLD;
                end else if (!PCStall) begin
                    slot_nxt = BUBBLE;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    slot_nxt  = BUBBLE;
                    state_nxt = FETCH;
                end else if (!PCStall) begin
                    slot_nxt  = '{pc: pc_inc, ir: hold_dat_q, vld: 1'b1};
                    pc_nxt    = pc_inc;
                    state_nxt = FETCH;
                end
            end

            DISCARD: begin
                if (redirect) begin
                    pc_nxt = target;
                end
                if (redirect || !PCStall) begin
                    slot_nxt = BUBBLE;
                end
                if (im_ready) begin
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
                slot_nxt  = BUBBLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= reset_pc;
            req_addr_q <= '0;
            hold_dat_q <= '0;
            slot_q     <= BUBBLE;
        end else begin
            state_q    <= state_nxt;
            pc_q       <= pc_nxt;
            req_addr_q <= req_addr_nxt;
            hold_dat_q <= hold_dat_nxt;
            slot_q     <= slot_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Purpose : directed checks of if_fetch_unit: streaming, stall/hold, discard, jump priority, wrap, reset.
// Latency : n/a (testbench).
// Backpr. : drives PCStall and im_ready directly.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PCStall;
    logic        Branch;
    logic [17:0] BranchAddr;
    logic        Jump;
    logic [17:0] JumpAddr;
    logic        im_req;
    logic [17:0] im_addr;
    logic        im_ready;
    logic [31:0] im_data;
    logic [17:0] IF_PC;
    logic [31:0] IF_ir;
    logic        IF_valid;

    int vec_cnt;
    int err_cnt;

    if_fetch_unit #(
        .pc_size  (18),
        .data_size(32),
        .reset_pc (18'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PCStall   (PCStall),
        .Branch    (Branch),
        .BranchAddr(BranchAddr),
        .Jump      (Jump),
        .JumpAddr  (JumpAddr),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_ready  (im_ready),
        .im_data   (im_data),
        .IF_PC     (IF_PC),
        .IF_ir     (IF_ir),
        .IF_valid  (IF_valid)
    );

    // Memory image: word at address A is A | 0xA5000000.
    assign im_data = 32'hA500_0000 | {14'd0, im_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                            input logic [31:0] vld);
        chk({tag, ".pc"},  32'(IF_PC),    pc);
        chk({tag, ".ir"},  IF_ir,         ir);
        chk({tag, ".vld"}, 32'(IF_valid), vld);
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        rst        = 1'b1;
        PCStall    = 1'b0;
        Branch     = 1'b0;
        BranchAddr = '0;
        Jump       = 1'b0;
        JumpAddr   = '0;
        im_ready   = 1'b1;

        // Reset state
        #1;
        chk("rst.im_req", 32'(im_req), 32'h0);
        chk_slot("rst.slot", 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst.im_req",  32'(im_req),  32'h1);
        chk("post_rst.im_addr", 32'(im_addr), 32'h0);

        // Zero-wait streaming from reset_pc
        tick(); chk_slot("seq0", 32'h4, 32'hA500_0000, 32'h1);
        tick(); chk_slot("seq1", 32'h8, 32'hA500_0004, 32'h1);
        tick(); chk_slot("seq2", 32'hC, 32'hA500_0008, 32'h1);
        tick(); chk_slot("seq3", 32'h10, 32'hA500_000C, 32'h1);
        chk("seq.im_addr", 32'(im_addr), 32'h10);

        // Stall 3 cycles at PC=0x10: word@0x10 parked, slot frozen
        PCStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.im_req",  32'(im_req),  32'h0);
            chk("stall.im_addr", 32'(im_addr), 32'h10);
            chk_slot("stall.slot", 32'h10, 32'hA500_000C, 32'h1);
        end
        PCStall = 1'b0;
        tick();
        chk_slot("unstall", 32'h14, 32'hA500_0010, 32'h1);
        chk("unstall.im_req",  32'(im_req),  32'h1);
        chk("unstall.im_addr", 32'(im_addr), 32'h14);
        tick(); chk_slot("seq4", 32'h18, 32'hA500_0014, 32'h1);
        tick(); chk_slot("seq5", 32'h1C, 32'hA500_0018, 32'h1);
        tick(); chk_slot("seq6", 32'h20, 32'hA500_001C, 32'h1);

        // Branch while memory busy at PC=0x20 -> DISCARD
        im_ready   = 1'b0;
        Branch     = 1'b1;
        BranchAddr = 18'h100;
        #1;
        chk("disc.pre_addr", 32'(im_addr), 32'h20);
        tick();
        Branch = 1'b0;
        #1;
        chk("disc0.im_req",  32'(im_req),  32'h1);
        chk("disc0.im_addr", 32'(im_addr), 32'h20);
        chk("disc0.vld",     32'(IF_valid), 32'h0);
        tick();
        chk("disc1.im_addr", 32'(im_addr), 32'h20);
        chk("disc1.vld",     32'(IF_valid), 32'h0);
        im_ready = 1'b1;
        tick();
        chk_slot("disc_done", 32'h0, 32'h0, 32'h0);
        chk("disc_done.im_addr", 32'(im_addr), 32'h100);
        tick();
        chk_slot("branch_tgt", 32'h104, 32'hA500_0100, 32'h1);

        // Jump and Branch together: Jump wins
        Jump       = 1'b1;
        JumpAddr   = 18'h200;
        Branch     = 1'b1;
        BranchAddr = 18'h300;
        tick();
        Jump   = 1'b0;
        Branch = 1'b0;
        #1;
        chk("jb.im_addr", 32'(im_addr), 32'h200);
        chk_slot("jb.bubble", 32'h0, 32'h0, 32'h0);
        tick();
        chk_slot("jb.tgt", 32'h204, 32'hA500_0200, 32'h1);

        // Redirect with PCStall: redirect wins; target at top of address space
        Jump     = 1'b1;
        JumpAddr = 18'h3FFFC;
        PCStall  = 1'b1;
        tick();
        Jump    = 1'b0;
        PCStall = 1'b0;
        #1;
        chk("rs.im_addr", 32'(im_addr), 32'h3FFFC);
        chk("rs.vld",     32'(IF_valid), 32'h0);
        tick();
        chk_slot("wrap", 32'h0, 32'hA503_FFFC, 32'h1);
        chk("wrap.im_addr", 32'(im_addr), 32'h0);
        tick();
        chk_slot("wrap_next", 32'h4, 32'hA500_0000, 32'h1);

        // Enter DISCARD with req_addr=4, then async reset mid-cycle
        im_ready   = 1'b0;
        Branch     = 1'b1;
        BranchAddr = 18'h40;
        tick();
        Branch = 1'b0;
        #1;
        chk("rd.im_addr", 32'(im_addr), 32'h4);
        chk("rd.im_req",  32'(im_req),  32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst.im_req",  32'(im_req),  32'h0);
        chk("arst.im_addr", 32'(im_addr), 32'h0);
        chk_slot("arst.slot", 32'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        // im_ready still low: DISCARD would show req_addr, FETCH shows reset_pc
        chk("arst_rel.im_req",  32'(im_req),  32'h1);
        chk("arst_rel.im_addr", 32'(im_addr), 32'h0);
        im_ready = 1'b1;
        tick();
        chk_slot("arst_first", 32'h4, 32'hA500_0000, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
